// File: rtl/uart_pkg.sv
// Shared UART types, default timing parameters and small helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    BITS      = 2'd2,
    WAIT_HIGH = 2'd3
  } rx_state_e;

  localparam int unsigned OVS_DEF       = 16;
  localparam int unsigned OVS_DIV_DEF   = 27;
  localparam int unsigned DATA_BITS_DEF = 8;

  // 2-of-3 vote used for mid-bit sampling
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample timebase: one-cycle tick every DIV clocks, phase-aligned to restart.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = OVS_DIV_DEF
) (
  input  logic clk,
  input  logic arst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // After restart in cycle R, tick k appears in cycle R + k*DIV
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
      tick <= (cnt == CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front-end: rxd synchroniser, start-bit validation and
// mid-bit majority voting of data and stop bits.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned OVS_DIV   = OVS_DIV_DEF,
  parameter int unsigned OVS       = OVS_DEF,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic clk,
  input  logic arst_n,
  input  logic rst,
  input  logic rx_en,
  input  logic rxd,
  output logic start_tick,
  output logic bit_en,
  output logic bit_val,
  output logic bit_is_stop,
  output logic stop_bit,
  output logic false_start,
  output logic busy
);

  localparam int unsigned SUB_W = $clog2(OVS);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);
  localparam logic [SUB_W-1:0] SMP_A    = SUB_W'(OVS / 2 - 1);
  localparam logic [SUB_W-1:0] SMP_B    = SUB_W'(OVS / 2);
  localparam logic [SUB_W-1:0] SMP_C    = SUB_W'(OVS / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS);

  rx_state_e        state;
  logic             sync_q, rxd_s, rxd_prev;
  logic [SUB_W-1:0] sub_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [1:0]       samp;
  logic             tick;
  logic             detect_c;
  logic             vote_c;

  // Two-flop synchroniser plus history flop for falling-edge detection
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q   <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else if (rst) begin
      sync_q   <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync_q   <= rxd;
      rxd_s    <= sync_q;
      rxd_prev <= rxd_s;
    end
  end

  assign detect_c = (state == IDLE) && rx_en && !rst && !rxd_s && rxd_prev;
  assign vote_c   = maj3(samp[0], samp[1], rxd_s);

  uart_os_tick #(
    .DIV (OVS_DIV)
  ) u_os_tick (
    .clk     (clk),
    .arst_n  (arst_n),
    .restart (detect_c),
    .tick    (tick)
  );

  // sub_cnt starts at 1 so that during tick k it reads k mod OVS
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      sub_cnt     <= '0;
      bit_cnt     <= '0;
      samp        <= '0;
      start_tick  <= 1'b0;
      bit_en      <= 1'b0;
      bit_val     <= 1'b0;
      bit_is_stop <= 1'b0;
      stop_bit    <= 1'b1;
      false_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_tick  <= 1'b0;
      bit_en      <= 1'b0;
      bit_is_stop <= 1'b0;
      false_start <= 1'b0;
      if (rst || !rx_en) begin
        state    <= IDLE;
        sub_cnt  <= '0;
        bit_cnt  <= '0;
        samp     <= '0;
        stop_bit <= 1'b1;
        busy     <= 1'b0;
        if (rst) bit_val <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // busy lingers through the cycle after a frame ends
            busy <= detect_c;
            if (detect_c) begin
              state   <= START_CHK;
              sub_cnt <= SUB_W'(1);
              bit_cnt <= '0;
            end
          end
          START_CHK, BITS: begin
            if (tick) begin
              sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + SUB_W'(1);
              if (sub_cnt == SMP_A) samp[0] <= rxd_s;
              if (sub_cnt == SMP_B) samp[1] <= rxd_s;
              if (sub_cnt == SMP_C) begin
                if (state == START_CHK) begin
                  if (vote_c) begin
                    false_start <= 1'b1;
                    state       <= IDLE;
                  end else begin
                    start_tick <= 1'b1;
                    state      <= BITS;
                    bit_cnt    <= '0;
                  end
                end else begin
                  bit_en  <= 1'b1;
                  bit_val <= vote_c;
                  if (bit_cnt == BIT_LAST) begin
                    bit_is_stop <= 1'b1;
                    stop_bit    <= vote_c;
                    state       <= vote_c ? IDLE : WAIT_HIGH;
                  end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                  end
                end
              end
            end
          end
          WAIT_HIGH: begin
            if (rxd_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
